// File: rtl/tmds_encoder.sv
// DVI TMDS encoder: three pipelined 8b/10b transition-minimised, DC-balanced
// channel encoders with 3-clk latency from pixel sample to symbol.
module tmds_channel (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] d,
  input  logic       de,
  input  logic [1:0] ctl,
  output logic [9:0] sym
);

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic [7:0]        d_r;
  logic [3:0]        n1_r;
  logic              de1_r;
  logic [1:0]        ctl1_r;
  logic [8:0]        qm_r;
  logic [3:0]        n1q_r;
  logic              de2_r;
  logic [1:0]        ctl2_r;
  logic [9:0]        sym_r;
  logic signed [4:0] cnt_r;

  logic              use_xnor_s;
  logic [8:0]        qm_s;
  logic [9:0]        sym_s;
  logic signed [4:0] cnt_s;
  logic signed [4:0] n1q_s;
  logic signed [4:0] diff_s;

  // Stage 1: capture data byte, its ones count, enable and control pair
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      d_r    <= 8'd0;
      n1_r   <= 4'd0;
      de1_r  <= 1'b0;
      ctl1_r <= 2'b00;
    end else begin
      d_r    <= d;
      n1_r   <= count_ones(d);
      de1_r  <= de;
      ctl1_r <= ctl;
    end
  end

  // Transition-minimised word q_m; bit 8 records XOR (1) vs XNOR (0)
  always_comb begin
    use_xnor_s = (n1_r > 4'd4) || ((n1_r == 4'd4) && (d_r[0] == 1'b0));
    qm_s       = 9'd0;
    qm_s[0]    = d_r[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor_s) begin
        qm_s[i] = ~(qm_s[i-1] ^ d_r[i]);
      end else begin
        qm_s[i] = qm_s[i-1] ^ d_r[i];
      end
    end
    qm_s[8] = ~use_xnor_s;
  end

  // Stage 2: register q_m and its ones count
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      qm_r   <= 9'd0;
      n1q_r  <= 4'd0;
      de2_r  <= 1'b0;
      ctl2_r <= 2'b00;
    end else begin
      qm_r   <= qm_s;
      n1q_r  <= count_ones(qm_s[7:0]);
      de2_r  <= de1_r;
      ctl2_r <= ctl1_r;
    end
  end

  // DC balancing against running disparity, or control token selection
  always_comb begin
    n1q_s  = signed'({1'b0, n1q_r});
    diff_s = n1q_s + n1q_s - 5'sd8;  // N1q - N0q
    sym_s  = 10'b1101010100;
    cnt_s  = 5'sd0;
    if (!de2_r) begin
      cnt_s = 5'sd0;
      case (ctl2_r)
        2'b00:   sym_s = 10'b1101010100;
        2'b01:   sym_s = 10'b0010101011;
        2'b10:   sym_s = 10'b0101010100;
        2'b11:   sym_s = 10'b1010101011;
        default: sym_s = 10'b1101010100;
      endcase
    end else if ((cnt_r == 5'sd0) || (n1q_r == 4'd4)) begin
      sym_s = {~qm_r[8], qm_r[8], (qm_r[8] ? qm_r[7:0] : ~qm_r[7:0])};
      cnt_s = qm_r[8] ? (cnt_r + diff_s) : (cnt_r - diff_s);
    end else if (((cnt_r > 5'sd0) && (n1q_r > 4'd4)) || ((cnt_r < 5'sd0) && (n1q_r < 4'd4))) begin
      sym_s = {1'b1, qm_r[8], ~qm_r[7:0]};
      cnt_s = cnt_r - diff_s + (qm_r[8] ? 5'sd2 : 5'sd0);
    end else begin
      sym_s = {1'b0, qm_r[8], qm_r[7:0]};
      cnt_s = cnt_r + diff_s - (qm_r[8] ? 5'sd0 : 5'sd2);
    end
  end

  // Stage 3: output symbol and running disparity
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sym_r <= 10'b1101010100;
      cnt_r <= 5'sd0;
    end else begin
      sym_r <= sym_s;
      cnt_r <= cnt_s;
    end
  end

  assign sym = sym_r;

endmodule

module tmds_encoder #(
  parameter int COLOR_W = 4,
  parameter int EN_CTL  = 0
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic [COLOR_W-1:0] red_i,
  input  logic [COLOR_W-1:0] green_i,
  input  logic [COLOR_W-1:0] blue_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               dv_de_i,
  input  logic [3:0]         ctl_i,
  output logic [9:0]         tmds_b_o,
  output logic [9:0]         tmds_g_o,
  output logic [9:0]         tmds_r_o,
  output logic               dv_de_o
);

  logic [7:0] red_s;
  logic [7:0] green_s;
  logic [7:0] blue_s;
  logic [1:0] ctl_g_s;
  logic [1:0] ctl_r_s;
  logic [2:0] de_pipe_r;

  generate
    if (COLOR_W == 8) begin : g_color8
      assign red_s   = red_i;
      assign green_s = green_i;
      assign blue_s  = blue_i;
    end else begin : g_color4
      assign red_s   = {red_i, red_i};
      assign green_s = {green_i, green_i};
      assign blue_s  = {blue_i, blue_i};
    end

    if (EN_CTL != 0) begin : g_ctl_on
      assign ctl_g_s = ctl_i[1:0];
      assign ctl_r_s = ctl_i[3:2];
    end else begin : g_ctl_off
      logic unused_ctl_s;
      assign unused_ctl_s = ^ctl_i;
      assign ctl_g_s      = 2'b00;
      assign ctl_r_s      = 2'b00;
    end
  endgenerate

  // Delay display enable to line up with the three-stage symbol pipeline
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      de_pipe_r <= 3'b000;
    end else begin
      de_pipe_r <= {de_pipe_r[1:0], dv_de_i};
    end
  end

  assign dv_de_o = de_pipe_r[2];

  tmds_channel u_ch_b (
    .clk(clk), .reset_i(reset_i), .d(blue_s), .de(dv_de_i),
    .ctl({vsync_i, hsync_i}), .sym(tmds_b_o)
  );

  tmds_channel u_ch_g (
    .clk(clk), .reset_i(reset_i), .d(green_s), .de(dv_de_i),
    .ctl(ctl_g_s), .sym(tmds_g_o)
  );

  tmds_channel u_ch_r (
    .clk(clk), .reset_i(reset_i), .d(red_s), .de(dv_de_i),
    .ctl(ctl_r_s), .sym(tmds_r_o)
  );

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: reset sequences, a directed vector table with
// hand-computed symbols, and a random run against a behavioural encoder.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] red, green, blue, ctl;
  logic       hsync, vsync, de;
  logic [9:0] b4, g4, r4, b8, g8, r8;
  logic       de4, de8;

  int checks = 0;
  int passes = 0;
  int cnt_m[5];

  typedef struct packed {
    logic       de, vs, hs;
    logic [3:0] red, green, blue, ctl;
    logic [9:0] b, g4, r4, g8, r8;
  } vec_t;

  typedef struct packed {
    logic       de;
    logic [9:0] b, g4, r4, g8, r8;
  } exp_t;

  vec_t       tbl[19];
  exp_t       exp_q[$];
  logic [9:0] rs_exp[7];
  logic       rs_de[7];

  always #5 clk = ~clk;

  tmds_encoder #(.COLOR_W(4), .EN_CTL(0)) u_dut4 (
    .clk(clk), .reset_i(reset), .red_i(red), .green_i(green), .blue_i(blue),
    .hsync_i(hsync), .vsync_i(vsync), .dv_de_i(de), .ctl_i(ctl),
    .tmds_b_o(b4), .tmds_g_o(g4), .tmds_r_o(r4), .dv_de_o(de4)
  );

  tmds_encoder #(.COLOR_W(8), .EN_CTL(1)) u_dut8 (
    .clk(clk), .reset_i(reset), .red_i({red, red}), .green_i({green, green}),
    .blue_i({blue, blue}), .hsync_i(hsync), .vsync_i(vsync), .dv_de_i(de),
    .ctl_i(ctl), .tmds_b_o(b8), .tmds_g_o(g8), .tmds_r_o(r8), .dv_de_o(de8)
  );

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input exp_t e, input string tag);
    check({tag, ".b4"}, b4, e.b);
    check({tag, ".b8"}, b8, e.b);
    check({tag, ".g4"}, g4, e.g4);
    check({tag, ".r4"}, r4, e.r4);
    check({tag, ".g8"}, g8, e.g8);
    check({tag, ".r8"}, r8, e.r8);
    check({tag, ".de4"}, {9'd0, de4}, {9'd0, e.de});
    check({tag, ".de8"}, {9'd0, de8}, {9'd0, e.de});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    de = 1'b0; hsync = 1'b0; vsync = 1'b0; ctl = 4'h0;
    red = 4'h0; green = 4'h0; blue = 4'h0;
  endtask

  task automatic drive(input vec_t v);
    de = v.de; vsync = v.vs; hsync = v.hs; ctl = v.ctl;
    red = v.red; green = v.green; blue = v.blue;
  endtask

  function automatic vec_t mk(input logic de_v, input logic vs_v, input logic hs_v,
                              input logic [3:0] r_v, input logic [3:0] g_v,
                              input logic [3:0] b_v, input logic [3:0] c_v,
                              input logic [9:0] eb, input logic [9:0] eg4,
                              input logic [9:0] er4, input logic [9:0] eg8,
                              input logic [9:0] er8);
    vec_t v;
    v.de = de_v; v.vs = vs_v; v.hs = hs_v; v.red = r_v; v.green = g_v;
    v.blue = b_v; v.ctl = c_v; v.b = eb; v.g4 = eg4; v.r4 = er4;
    v.g8 = eg8; v.r8 = er8;
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.de = v.de; e.b = v.b; e.g4 = v.g4; e.r4 = v.r4; e.g8 = v.g8; e.r8 = v.r8;
    return e;
  endfunction

  // Behavioural DVI encoder with integer disparity per channel index
  function automatic logic [9:0] model(input logic [7:0] d, input logic de_v,
                                       input logic [1:0] c, input int ch);
    int         n1, n1q;
    bit         xn;
    logic [8:0] qm;
    logic [9:0] s;
    if (!de_v) begin
      cnt_m[ch] = 0;
      case (c)
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
      return s;
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm = 9'd0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1q = $countones(qm[7:0]);
    if (cnt_m[ch] == 0 || n1q == 4) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_m[ch] += qm[8] ? (2 * n1q - 8) : (8 - 2 * n1q);
    end else if ((cnt_m[ch] > 0 && n1q > 4) || (cnt_m[ch] < 0 && n1q < 4)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      cnt_m[ch] += 2 * int'(qm[8]) + 8 - 2 * n1q;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      cnt_m[ch] += 2 * n1q - 8 - 2 * int'(!qm[8]);
    end
    return s;
  endfunction

  initial begin
    exp_t e;

    // de, vs, hs, red, green, blue, ctl | b, g4, r4, g8, r8
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b1001, 10'h354, 10'h354, 10'h354, 10'h0AB, 10'h154);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'b0000, 10'h0AB, 10'h354, 10'h354, 10'h354, 10'h354);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0110, 10'h154, 10'h354, 10'h354, 10'h154, 10'h0AB);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'b1111, 10'h2AB, 10'h354, 10'h354, 10'h2AB, 10'h2AB);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 10'h200, 10'h100, 10'h100, 10'h100, 10'h100);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 10'h0FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 10'h0FF, 10'h100, 10'h100, 10'h100, 10'h100);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 10'h200, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 10'h100, 10'h100, 10'h133, 10'h100, 10'h133);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 10'h100, 10'h100, 10'h133, 10'h100, 10'h133);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 10'h100, 10'h100, 10'h100, 10'h100, 10'h100);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h5, 4'h0, 10'h133, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 10'h3FF, 10'h100, 10'h100, 10'h100, 10'h100);
    tbl[16] = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hA, 4'h0, 10'h233, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h3, 4'h0, 10'h111, 10'h100, 10'h100, 10'h100, 10'h100);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h3, 4'h0, 10'h3EE, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);

    rs_exp = '{10'h354, 10'h354, 10'h354, 10'h100, 10'h3FF, 10'h100, 10'h3FF};
    rs_de  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Power-on reset
    reset = 1'b1;
    idle();
    repeat (2) tick();
    e = '{de: 1'b0, b: 10'h354, g4: 10'h354, r4: 10'h354, g8: 10'h354, r8: 10'h354};
    check_all(e, "por");

    // Active video, then asynchronous reset mid-cycle
    reset = 1'b0;
    de = 1'b1;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1 check_all(e, "async_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      e = '{de: rs_de[k], b: rs_exp[k], g4: rs_exp[k], r4: rs_exp[k], g8: rs_exp[k], r8: rs_exp[k]};
      check_all(e, $sformatf("rel%0d", k));
    end

    // Directed vector table; outputs trail inputs by two ticks at this sample point
    for (int i = 0; i < 21; i++) begin
      if (i < 19) drive(tbl[i]);
      else idle();
      tick();
      if (i >= 2) check_all(to_exp(tbl[i-2]), $sformatf("vec%0d", i - 2));
    end

    // Random pixels with de toggling, checked against the behavioural encoder
    idle();
    repeat (3) tick();
    for (int c = 0; c < 5; c++) cnt_m[c] = 0;
    for (int n = 0; n < 2000; n++) begin
      red   = 4'($urandom_range(0, 15));
      green = 4'($urandom_range(0, 15));
      blue  = 4'($urandom_range(0, 15));
      ctl   = 4'($urandom_range(0, 15));
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      de    = ($urandom_range(0, 5) != 0);
      e.de  = de;
      e.b   = model({blue, blue}, de, {vsync, hsync}, 0);
      e.g4  = model({green, green}, de, 2'b00, 1);
      e.r4  = model({red, red}, de, 2'b00, 2);
      e.g8  = model({green, green}, de, ctl[1:0], 3);
      e.r8  = model({red, red}, de, ctl[3:2], 4);
      exp_q.push_back(e);
      tick();
      if (exp_q.size() == 3) check_all(exp_q.pop_front(), $sformatf("rnd%0d", n - 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
